// File: rtl/rtc_bus_scheduler.sv
// ---------------------------------------------------------------------------
// rtc_bus_scheduler
//
// Sequences every access on the multiplexed RTC parallel bus. Two requesters
// share the bus:
//   * a periodic refresh sweep that reads the nine time/date/timer registers
//     which feed the VGA digit outputs, and
//   * single-register writes issued by the PS/2-driven programming logic.
// Writes win arbitration in IDLE but never preempt a running transaction. A
// sweep interrupted by a write resumes at its saved index.
//
// Every transaction runs ADR_ST -> ADR_HLD -> DAT_ST -> REC. Each phase lasts
// PHASE_CYC clocks, and at least one IDLE cycle separates transactions.
//
// Ports
//   clk, reset          system clock, synchronous active-low reset
//   rd_en               enables periodic refresh sweeps
//   wr_req/addr/data    level write request (held until wr_ack), sampled at grant
//   wr_ack              1-cycle pulse: write finished
//   rd_valid            1-cycle pulse: rd_addr/rd_data hold a finished read
//   sweep_done          1-cycle pulse with the 9th sweep read
//   busy                high from ADR_ST through REC
//   A_D, RD, WR, CS     bus strobes (A_D: 0 = address phase; others active low)
//   bus_dout, bus_oe    data and output enable for the io_port tristate
//   bus_din             sampled io_port value
// ---------------------------------------------------------------------------
module rtc_bus_scheduler #(
    parameter int PHASE_CYC   = 10,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_en,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       sweep_done,
    output logic       busy,
    output logic       A_D,
    output logic       RD,
    output logic       WR,
    output logic       CS,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int CW = $clog2(REFRESH_DIV);

    localparam logic [PW-1:0] PH_LAST  = PW'(PHASE_CYC - 1);
    localparam logic [PW-1:0] PH_PRE   = PW'((PHASE_CYC > 1) ? PHASE_CYC - 2 : 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    // Sweep registers, index 0 in the least significant byte.
    localparam logic [71:0] SWEEP_TABLE = {8'h43, 8'h42, 8'h41, 8'h26, 8'h25,
                                           8'h24, 8'h23, 8'h22, 8'h21};

    typedef enum logic [2:0] {IDLE, ADR_ST, ADR_HLD, DAT_ST, REC} state_t;

    state_t          state_reg;
    logic [PW-1:0]   phase_reg;
    logic [CW-1:0]   cnt_reg;
    logic            pending_reg;
    logic [3:0]      sweep_idx_reg;
    logic            is_wr_reg;
    logic [7:0]      addr_reg;
    logic [7:0]      data_reg;

    logic [7:0]      sweep_rom [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_sweep_rom
            assign sweep_rom[gi] = SWEEP_TABLE[gi*8 +: 8];
        end
    endgenerate

    logic phase_last;
    logic wrap;
    logic done_now;
    logic sweep_end;

    assign phase_last = (phase_reg == PH_LAST);
    assign wrap       = (cnt_reg == CNT_LAST);

    // The completion pulse is registered, so it is raised on the edge that
    // enters the last REC cycle. With single-cycle phases that edge is the
    // one leaving DAT_ST.
    assign done_now  = (PHASE_CYC == 1) ? (state_reg == DAT_ST && phase_last)
                                        : (state_reg == REC && phase_reg == PH_PRE);
    assign sweep_end = done_now && !is_wr_reg && (sweep_idx_reg == 4'd8);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            cnt_reg       <= '0;
            pending_reg   <= 1'b0;
            sweep_idx_reg <= 4'd0;
            is_wr_reg     <= 1'b0;
            addr_reg      <= 8'h00;
            data_reg      <= 8'h00;
            A_D           <= 1'b1;
            RD            <= 1'b1;
            WR            <= 1'b1;
            CS            <= 1'b1;
            bus_oe        <= 1'b0;
            bus_dout      <= 8'h00;
            wr_ack        <= 1'b0;
            rd_valid      <= 1'b0;
            sweep_done    <= 1'b0;
            busy          <= 1'b0;
            rd_addr       <= 8'h00;
            rd_data       <= 8'h00;
        end else begin
            wr_ack     <= 1'b0;
            rd_valid   <= 1'b0;
            sweep_done <= 1'b0;

            // Refresh timebase. A wrap only arms a sweep when none is pending
            // or running; the edge that finishes a sweep counts as free.
            cnt_reg <= wrap ? '0 : cnt_reg + CW'(1);
            if (wrap && rd_en && (!pending_reg || sweep_end)) begin
                pending_reg <= 1'b1;
            end else if (sweep_end) begin
                pending_reg <= 1'b0;
            end

            if (done_now) begin
                if (is_wr_reg) begin
                    wr_ack <= 1'b1;
                end else begin
                    rd_valid <= 1'b1;
                    rd_addr  <= addr_reg;
                    if (sweep_idx_reg == 4'd8) begin
                        sweep_idx_reg <= 4'd0;
                        sweep_done    <= 1'b1;
                    end else begin
                        sweep_idx_reg <= sweep_idx_reg + 4'd1;
                    end
                end
            end

            if (state_reg != IDLE) begin
                phase_reg <= phase_last ? '0 : phase_reg + PW'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (wr_req || pending_reg) begin
                        state_reg <= ADR_ST;
                        phase_reg <= '0;
                        is_wr_reg <= wr_req;
                        addr_reg  <= wr_req ? wr_addr : sweep_rom[sweep_idx_reg];
                        bus_dout  <= wr_req ? wr_addr : sweep_rom[sweep_idx_reg];
                        if (wr_req) begin
                            data_reg <= wr_data;
                        end
                        A_D    <= 1'b0;
                        CS     <= 1'b0;
                        WR     <= 1'b0;
                        RD     <= 1'b1;
                        bus_oe <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ADR_ST: begin
                    if (phase_last) begin
                        state_reg <= ADR_HLD;
                        CS        <= 1'b1;
                        WR        <= 1'b1;
                    end
                end
                ADR_HLD: begin
                    if (phase_last) begin
                        state_reg <= DAT_ST;
                        A_D       <= 1'b1;
                        CS        <= 1'b0;
                        if (is_wr_reg) begin
                            WR       <= 1'b0;
                            bus_dout <= data_reg;
                            bus_oe   <= 1'b1;
                        end else begin
                            RD     <= 1'b0;
                            bus_oe <= 1'b0;
                        end
                    end
                end
                DAT_ST: begin
                    if (phase_last) begin
                        state_reg <= REC;
                        if (!is_wr_reg) begin
                            rd_data <= bus_din;
                        end
                        CS     <= 1'b1;
                        WR     <= 1'b1;
                        RD     <= 1'b1;
                        bus_oe <= 1'b0;
                    end
                end
                REC: begin
                    if (phase_last) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    phase_reg <= '0;
                    A_D       <= 1'b1;
                    RD        <= 1'b1;
                    WR        <= 1'b1;
                    CS        <= 1'b1;
                    bus_oe    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_scheduler
//
// Scoreboard bench for rtc_bus_scheduler (PHASE_CYC=2, REFRESH_DIV=64).
// Stimulus pushes the expected completions (reads with addr/data, writes,
// sweep_done flag) into exp_q. A forked monitor pops an entry on every
// rd_valid / wr_ack and also checks bus invariants each cycle. The RTC is
// modelled as a register that latches the address phase and returns addr+1
// on reads.
// ---------------------------------------------------------------------------
module tb_rtc_bus_scheduler;

    localparam int PHASE_CYC   = 2;
    localparam int REFRESH_DIV = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_en;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       rd_valid;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       sweep_done;
    logic       busy;
    logic       A_D;
    logic       RD;
    logic       WR;
    logic       CS;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic [7:0] bus_din;

    rtc_bus_scheduler #(
        .PHASE_CYC   (PHASE_CYC),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .sweep_done (sweep_done),
        .busy       (busy),
        .A_D        (A_D),
        .RD         (RD),
        .WR         (WR),
        .CS         (CS),
        .bus_dout   (bus_dout),
        .bus_oe     (bus_oe),
        .bus_din    (bus_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        bit         done;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rdv    = 0;
    int         busy_run = 0;
    logic [7:0] lat_addr = 8'h00;
    logic [7:0] bw_addr  = 8'h00;
    logic [7:0] bw_data  = 8'h00;
    int         since_rst = 0;
    logic [7:0] tbl [9];

    // RTC model: reads return the latched address plus one.
    assign bus_din = !RD ? lat_addr + 8'd1 : 8'h00;

    // Clock edges since the last reset edge; mirrors the refresh timebase.
    always @(posedge clk) begin
        if (!reset) since_rst <= 0;
        else        since_rst <= since_rst + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor_cycle();
        exp_t e;
        if (!A_D && bus_oe) lat_addr = bus_dout;
        if (!WR && A_D && !CS && bus_oe) begin
            bw_addr = lat_addr;
            bw_data = bus_dout;
        end
        check("strobe_rules", {30'd0, (!RD && !WR), (!RD && bus_oe)}, 32'd0);
        busy_run = busy ? busy_run + 1 : 0;
        if (rd_valid) n_rdv++;
        if (rd_valid || wr_ack) begin
            check("single_pulse", {31'd0, rd_valid && wr_ack}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_completion: rd_valid=%0b wr_ack=%0b rd_addr=0x%02h, nothing expected",
                         rd_valid, wr_ack, rd_addr);
            end else begin
                e = exp_q.pop_front();
                check("kind_wr_ack", {31'd0, wr_ack}, {31'd0, e.is_wr});
                check("busy_len", busy_run, 4 * PHASE_CYC);
                check("sweep_done", {31'd0, sweep_done}, {31'd0, e.done});
                if (e.is_wr) begin
                    check("wr_bus_addr", bw_addr, e.addr);
                    check("wr_bus_data", bw_data, e.data);
                end else begin
                    check("rd_addr", rd_addr, e.addr);
                    check("rd_data", rd_data, e.data);
                end
                $display("txn %s addr=0x%02h data=0x%02h sweep_done=%0b t=%0t",
                         e.is_wr ? "WRITE" : "READ ", e.addr, e.data, sweep_done, $time);
            end
        end else begin
            check("sweep_done_alone", {31'd0, sweep_done}, 32'd0);
        end
    endtask

    task automatic wait_mod(input int m);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((since_rst % REFRESH_DIV) != m && k < 200);
        check("wait_mod_timeout", {31'd0, k >= 200}, 32'd0);
    endtask

    // Raise rd_en across exactly one counter wrap.
    task automatic arm_sweep();
        wait_mod(REFRESH_DIV - 4);
        rd_en = 1'b1;
        wait_mod(2);
        rd_en = 1'b0;
    endtask

    task automatic push_sweep(input int wr_after, input logic [7:0] wa, input logic [7:0] wd);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            e.is_wr = 1'b0;
            e.addr  = tbl[i];
            e.data  = tbl[i] + 8'd1;
            e.done  = (i == 8);
            exp_q.push_back(e);
            if (i == wr_after) begin
                e.is_wr = 1'b1;
                e.addr  = wa;
                e.data  = wd;
                e.done  = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [6:0] wexp  [9];
        logic [7:0] wdout [9];
        bit         wchk  [9];
        exp_t       e;
        int         n0;
        int         k;

        tbl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        // {A_D, CS, WR, RD, bus_oe, busy, wr_ack} for the 8 busy cycles + 1 idle
        wexp  = '{7'b0001110, 7'b0001110, 7'b0111110, 7'b0111110,
                  7'b1001110, 7'b1001110, 7'b1111010, 7'b1111011, 7'b1111000};
        wdout = '{8'h22, 8'h22, 8'h22, 8'h22, 8'h45, 8'h45, 8'h00, 8'h00, 8'h00};
        wchk  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};

        reset   = 1'b0;
        rd_en   = 1'b0;
        wr_req  = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;

        fork
            begin
                repeat (20000) @(posedge clk);
                $display("FAIL watchdog: simulation exceeded 20000 cycles");
                $fatal(1, "watchdog expired");
            end
        join_none

        @(negedge clk);
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        // Reset values
        @(negedge clk);
        check("rst_ctrl", {A_D, RD, WR, CS, bus_oe, busy, wr_ack, rd_valid, sweep_done}, 9'b111100000);
        check("rst_rd_addr", rd_addr, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_bus_dout", bus_dout, 8'h00);
        reset = 1'b1;

        // Idle with no requesters
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctrl", {A_D, RD, WR, CS, bus_oe, busy, wr_ack, rd_valid, sweep_done}, 9'b111100000);
        end

        // Single write, checked cycle by cycle
        e.is_wr = 1'b1; e.addr = 8'h22; e.data = 8'h45; e.done = 1'b0;
        exp_q.push_back(e);
        wr_addr = 8'h22;
        wr_data = 8'h45;
        wr_req  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("wr_phase_ctrl", {A_D, CS, WR, RD, bus_oe, busy, wr_ack}, wexp[c]);
            if (wchk[c]) check("wr_phase_dout", bus_dout, wdout[c]);
            if (c == 7) wr_req = 1'b0;
        end
        wait_drain("write_drain");

        // Full sweep; rd_en drops right after the wrap and must not abort it
        push_sweep(-1, 8'h00, 8'h00);
        arm_sweep();
        wait_drain("sweep1_drain");

        // rd_en pulsed between wraps: no sweep
        n0 = n_rdv;
        wait_mod(10);
        rd_en = 1'b1;
        wait_mod(50);
        rd_en = 1'b0;
        wait_mod(40);
        check("no_sweep_rdv", n_rdv, n0);
        check("no_sweep_busy", {31'd0, busy}, 32'd0);

        // Write interleaved after the 0x24 read
        push_sweep(3, 8'h31, 8'h5A);
        arm_sweep();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rd_valid && rd_addr == 8'h23) && k < 200);
        check("wait_rd23_timeout", {31'd0, k >= 200}, 32'd0);
        repeat (3) @(negedge clk);
        wr_addr = 8'h31;
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wr_ack && k < 100);
        check("wait_wr_ack_timeout", {31'd0, k >= 100}, 32'd0);
        wr_req = 1'b0;
        wait_drain("sweep2_drain");

        // Reset during the data phase of a read
        arm_sweep();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(A_D && !RD) && k < 100);
        check("wait_dat_timeout", {31'd0, k >= 100}, 32'd0);
        n0 = n_rdv;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {A_D, RD, WR, CS, bus_oe, busy, wr_ack, rd_valid, sweep_done}, 9'b111100000);
        check("abort_rd_data", rd_data, 8'h00);
        check("abort_rd_addr", rd_addr, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_rdv", n_rdv, n0);

        // Counter and index restart: first sweep after reset starts at 0x21
        push_sweep(-1, 8'h00, 8'h00);
        arm_sweep();
        wait_drain("sweep3_drain");

        repeat (5) @(negedge clk);
        check("final_queue", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Sequences every access on the multiplexed RTC parallel bus (A_D, RD, WR, CS, shared 8-bit data port).
- Arbitrates between two requesters:
  - a periodic refresh sweep that reads the nine time/date/timer registers feeding the VGA digit outputs;
  - single-register write requests from the PS/2-driven programming logic.
- Sits between the RTC programming FSM and the board-level tristate on io_port.

Parameters:
- PHASE_CYC, 10, clk cycles each bus phase is held (≥1).
- REFRESH_DIV, 100000, clk cycles between refresh-sweep triggers (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rd_en  in  1  enables periodic refresh sweeps
- wr_req  in  1  write request, level; held until wr_ack
- wr_addr  in  8  RTC register address, sampled at grant
- wr_data  in  8  write data, sampled at grant
- wr_ack  out  1  one-cycle pulse, write transaction complete
- rd_valid  out  1  one-cycle pulse, rd_addr/rd_data valid
- rd_addr  out  8  address of completed read
- rd_data  out  8  data captured from bus
- sweep_done  out  1  one-cycle pulse after the 9th sweep read
- busy  out  1  high while a transaction is in progress
- A_D  out  1  0 = address phase, 1 = data phase
- RD  out  1  read strobe, active low
- WR  out  1  write strobe, active low
- CS  out  1  chip select, active low
- bus_dout  out  8  data driven to io_port
- bus_oe  out  1  1 = drive io_port with bus_dout
- bus_din  in  8  io_port sampled value

Behaviour:
- Reset (reset=0 at a clk edge):
  - A_D=1, RD=1, WR=1, CS=1, bus_oe=0, bus_dout=0.
  - wr_ack=0, rd_valid=0, sweep_done=0, busy=0, rd_addr=0, rd_data=0.
  - Refresh counter=0, sweep index=0, pending=0, FSM=IDLE.
  - Reset mid-transaction aborts it; bus is released at that edge with no ack or valid pulse.
- Sweep table, index 0..8: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap with rd_en=1, sets pending.
  - A wrap while pending is already set or a sweep is active is dropped; there is no queuing.
  - rd_en=0 does not abort a sweep already pending or in progress.
- FSM states, each active state lasts exactly PHASE_CYC cycles:
  - IDLE: all strobes high, bus_oe=0, busy=0. Grant is evaluated every IDLE cycle:
    - wr_req=1 → grant write; latch wr_addr/wr_data.
    - else pending=1 → grant read at the current sweep index.
    - else stay in IDLE.
    - The grant cycle moves to ADR_ST on the next edge.
  - ADR_ST: A_D=0, CS=0, WR=0, bus_oe=1, bus_dout=addr.
  - ADR_HLD: A_D=0, CS=1, WR=1, bus_oe=1, bus_dout=addr (address hold).
  - DAT_ST:
    - Write: A_D=1, CS=0, WR=0, bus_oe=1, bus_dout=data.
    - Read: A_D=1, CS=0, RD=0, bus_oe=0.
    - Read data: rd_data←bus_din on the last DAT_ST cycle.
  - REC: all strobes high, A_D=1, bus_oe=0. On the last REC cycle, pulse wr_ack (write) or rd_valid (read, with rd_addr) for one cycle, then return to IDLE.
- busy=1 from ADR_ST through REC inclusive.
- Total transaction length is 4*PHASE_CYC cycles plus at least one IDLE cycle between transactions.
- RD and WR are never low in the same cycle.
- bus_oe=0 whenever RD=0.
- Arbitration:
  - Writes have fixed priority but never preempt a transaction in progress.
  - Writes may interleave between sweep reads; the sweep resumes at the saved index.
- Sweep completion:
  - After index 8 completes, the index wraps to 0, pending clears, and sweep_done pulses in the same cycle as the final rd_valid.
- Simultaneous events:
  - wr_req and pending both high in IDLE → write first.
  - A counter wrap on the same cycle a sweep ends sets pending again only if rd_en=1.

Test Plan (PHASE_CYC=2, REFRESH_DIV=64):
- Reset, then idle 10 cycles with rd_en=0, wr_req=0 → strobes/A_D all 1, bus_oe=0, busy=0, no pulses.
- wr_req=1, wr_addr=0x22, wr_data=0x45 → next cycle ADR_ST with bus_dout=0x22, A_D=0, WR=0, CS=0 for 2 cycles; ADR_HLD 2 cycles; DAT_ST with bus_dout=0x45, WR=0 for 2 cycles; REC 2 cycles; wr_ack pulse on the 8th busy cycle.
- rd_en=1, bus model returns addr+1 → after 64 cycles, 9 reads at 0x21..0x26, 0x41..0x43; each rd_valid shows rd_data=rd_addr+1; sweep_done coincides with rd_addr=0x43.
- wr_req asserted during sweep read index 3 → read 0x24 completes, then the write executes, then the sweep resumes at 0x25; no read is skipped or repeated.
- reset=0 during DAT_ST of a read → bus released at that edge; no rd_valid; after release, counter restarts from 0 and the first sweep begins at 0x21.
- rd_en toggled 0 before the wrap → no sweep; rd_en=0 mid-sweep → the sweep finishes all 9 reads.
